// File: rtl/branch_rs.sv
// branch_rs: in-order reservation station for control-flow µops (JAL, JALR,
// conditional branches). Buffers dispatched branches in a circular queue,
// snoops the CDB for missing source operands, and issues the oldest branch
// to the comparator once both of its operands are ready.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             squash: empties the queue, suppresses issue
//   dispatch_*        incoming branch µop (instr/pc/imm/tag + two sources)
//   rs_full           combinational: station holds RS_DEPTH entries
//   cdb_valid/tag/data  common data bus broadcast
//   rs1_v, rs2_v, pc, imm, instr, branch_tag  registered issue payload
//   comp_issue        registered issue strobe, one cycle per issued entry
module branch_rs #(
  parameter int unsigned ROB_DEPTH = 4,
  parameter int unsigned RS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  input  logic [31:0]                  dispatch_instr,
  input  logic [31:0]                  dispatch_pc,
  input  logic [31:0]                  dispatch_imm,
  input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_tag,
  input  logic                         dispatch_rs1_ready,
  input  logic [31:0]                  dispatch_rs1_v,
  input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_rs1_tag,
  input  logic                         dispatch_rs2_ready,
  input  logic [31:0]                  dispatch_rs2_v,
  input  logic [$clog2(ROB_DEPTH)-1:0] dispatch_rs2_tag,
  output logic                         rs_full,
  input  logic                         cdb_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] cdb_tag,
  input  logic [31:0]                  cdb_data,
  output logic [31:0]                  rs1_v,
  output logic [31:0]                  rs2_v,
  output logic [31:0]                  pc,
  output logic [31:0]                  imm,
  output logic [31:0]                  instr,
  output logic [$clog2(ROB_DEPTH)-1:0] branch_tag,
  output logic                         comp_issue
);

  localparam int unsigned TW = $clog2(ROB_DEPTH);
  localparam int unsigned PW = $clog2(RS_DEPTH);
  localparam int unsigned CW = PW + 1;

  // RV32 base opcodes for the control-flow classes handled here
  localparam logic [6:0] OP_B_JAL  = 7'b1101111;
  localparam logic [6:0] OP_B_JALR = 7'b1100111;
  localparam logic [6:0] OP_B_BR   = 7'b1100011;

  typedef struct packed {
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [TW-1:0] tag;
    logic          rs1_rdy;
    logic [31:0]   rs1_v;
    logic [TW-1:0] rs1_tag;
    logic          rs2_rdy;
    logic [31:0]   rs2_v;
    logic [TW-1:0] rs2_tag;
  } entry_t;

  entry_t                ent_q [RS_DEPTH];
  entry_t                ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0]   vld_q, vld_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic [31:0]           rs1_v_q, rs1_v_d;
  logic [31:0]           rs2_v_q, rs2_v_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           imm_q, imm_d;
  logic [31:0]           instr_q, instr_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic                  issue_q, issue_d;

  logic                  do_disp;
  logic                  do_issue;
  logic                  force1, force2;
  entry_t                new_ent;

  assign rs_full = (count_q == CW'(RS_DEPTH));

  assign do_disp  = dispatch_valid && !rs_full;
  assign do_issue = (count_q != '0) && ent_q[head_q].rs1_rdy && ent_q[head_q].rs2_rdy;

  // Opcode-based ready forcing for sources the instruction does not read
  always_comb begin
    force1 = 1'b0;
    force2 = 1'b0;
    case (dispatch_instr[6:0])
      OP_B_JAL:  begin force1 = 1'b1; force2 = 1'b1; end
      OP_B_JALR: begin force2 = 1'b1; end
      OP_B_BR:   begin end
      default:   begin end
    endcase
  end

  // Build the entry to be written, including same-cycle CDB bypass
  always_comb begin
    new_ent         = '0;
    new_ent.instr   = dispatch_instr;
    new_ent.pc      = dispatch_pc;
    new_ent.imm     = dispatch_imm;
    new_ent.tag     = dispatch_tag;
    new_ent.rs1_tag = dispatch_rs1_tag;
    new_ent.rs2_tag = dispatch_rs2_tag;
    new_ent.rs1_v   = dispatch_rs1_v;
    new_ent.rs2_v   = dispatch_rs2_v;
    new_ent.rs1_rdy = dispatch_rs1_ready || force1;
    new_ent.rs2_rdy = dispatch_rs2_ready || force2;
    if (!new_ent.rs1_rdy && cdb_valid && (cdb_tag == dispatch_rs1_tag)) begin
      new_ent.rs1_rdy = 1'b1;
      new_ent.rs1_v   = cdb_data;
    end
    if (!new_ent.rs2_rdy && cdb_valid && (cdb_tag == dispatch_rs2_tag)) begin
      new_ent.rs2_rdy = 1'b1;
      new_ent.rs2_v   = cdb_data;
    end
  end

  // Next-state: wakeup, issue, dispatch, count; flush overrides all of it
  always_comb begin
    ent_d     = ent_q;
    vld_d     = vld_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rs1_v_d   = rs1_v_q;
    rs2_v_d   = rs2_v_q;
    pc_d      = pc_q;
    imm_d     = imm_q;
    instr_d   = instr_q;
    tag_d     = tag_q;
    issue_d   = 1'b0;

    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (vld_q[i] && cdb_valid) begin
        if (!ent_q[i].rs1_rdy && (ent_q[i].rs1_tag == cdb_tag)) begin
          ent_d[i].rs1_rdy = 1'b1;
          ent_d[i].rs1_v   = cdb_data;
        end
        if (!ent_q[i].rs2_rdy && (ent_q[i].rs2_tag == cdb_tag)) begin
          ent_d[i].rs2_rdy = 1'b1;
          ent_d[i].rs2_v   = cdb_data;
        end
      end
    end

    if (do_issue) begin
      rs1_v_d       = ent_q[head_q].rs1_v;
      rs2_v_d       = ent_q[head_q].rs2_v;
      pc_d          = ent_q[head_q].pc;
      imm_d         = ent_q[head_q].imm;
      instr_d       = ent_q[head_q].instr;
      tag_d         = ent_q[head_q].tag;
      issue_d       = 1'b1;
      vld_d[head_q] = 1'b0;
      ent_d[head_q].rs1_rdy = 1'b0;
      ent_d[head_q].rs2_rdy = 1'b0;
      head_d        = head_q + PW'(1);
    end

    if (do_disp) begin
      ent_d[tail_q] = new_ent;
      vld_d[tail_q] = 1'b1;
      tail_d        = tail_q + PW'(1);
    end

    if (do_disp && !do_issue) begin
      count_d = count_q + CW'(1);
    end else if (!do_disp && do_issue) begin
      count_d = count_q - CW'(1);
    end

    if (flush) begin
      vld_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      issue_d = 1'b0;
      rs1_v_d = rs1_v_q;
      rs2_v_d = rs2_v_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      instr_d = instr_q;
      tag_d   = tag_q;
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        ent_d[i]         = ent_q[i];
        ent_d[i].rs1_rdy = 1'b0;
        ent_d[i].rs2_rdy = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rs1_v_q <= '0;
      rs2_v_q <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      instr_q <= '0;
      tag_q   <= '0;
      issue_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rs1_v_q <= rs1_v_d;
      rs2_v_q <= rs2_v_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      instr_q <= instr_d;
      tag_q   <= tag_d;
      issue_q <= issue_d;
    end
  end

  assign rs1_v      = rs1_v_q;
  assign rs2_v      = rs2_v_q;
  assign pc         = pc_q;
  assign imm        = imm_q;
  assign instr      = instr_q;
  assign branch_tag = tag_q;
  assign comp_issue = issue_q;

endmodule

// File: tb/tb_branch_rs.sv
// tb_branch_rs: scoreboard bench for branch_rs. Expected issue payloads are
// queued when µops are dispatched; a negedge monitor pops and compares them
// whenever comp_issue is high. Directed checks cover issue timing, rs_full
// and flush behaviour.
module tb_branch_rs;

  localparam int unsigned TW = 2;

  localparam logic [31:0] I_BEQ  = 32'h00628063;
  localparam logic [31:0] I_BNE  = 32'h00629063;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_JALR = 32'h000080E7;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          dispatch_valid;
  logic [31:0]   dispatch_instr, dispatch_pc, dispatch_imm;
  logic [TW-1:0] dispatch_tag;
  logic          dispatch_rs1_ready, dispatch_rs2_ready;
  logic [31:0]   dispatch_rs1_v, dispatch_rs2_v;
  logic [TW-1:0] dispatch_rs1_tag, dispatch_rs2_tag;
  logic          rs_full;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic [31:0]   rs1_v, rs2_v, pc, imm, instr;
  logic [TW-1:0] branch_tag;
  logic          comp_issue;

  typedef struct {
    logic [31:0]   r1;
    logic [31:0]   r2;
    logic [31:0]   pc;
    logic [31:0]   imm;
    logic [31:0]   ins;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  branch_rs #(.ROB_DEPTH(4), .RS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_instr(dispatch_instr),
    .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
    .dispatch_tag(dispatch_tag),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs1_v(dispatch_rs1_v),
    .dispatch_rs1_tag(dispatch_rs1_tag),
    .dispatch_rs2_ready(dispatch_rs2_ready), .dispatch_rs2_v(dispatch_rs2_v),
    .dispatch_rs2_tag(dispatch_rs2_tag),
    .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .pc(pc), .imm(imm), .instr(instr),
    .branch_tag(branch_tag), .comp_issue(comp_issue)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  // Scoreboard monitor: every issue must match the oldest outstanding µop
  always @(negedge clk) begin
    if (!rst && comp_issue) begin
      if (sb.size() == 0) begin
        chk("sb_extra_issue", 32'(comp_issue), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rs1", rs1_v, e.r1);
        chk("sb_rs2", rs2_v, e.r2);
        chk("sb_pc", pc, e.pc);
        chk("sb_imm", imm, e.imm);
        chk("sb_instr", instr, e.ins);
        chk("sb_tag", 32'(branch_tag), 32'(e.tag));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one dispatch for one edge; push the expected issue when it should issue
  task automatic disp(input logic [31:0] ins, input logic [31:0] p, input logic [TW-1:0] t,
                      input logic r1r, input logic [31:0] r1v, input logic [TW-1:0] r1t,
                      input logic r2r, input logic [31:0] r2v, input logic [TW-1:0] r2t,
                      input bit push, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    dispatch_valid     = 1'b1;
    dispatch_instr     = ins;
    dispatch_pc        = p;
    dispatch_imm       = p ^ 32'h0000_1234;
    dispatch_tag       = t;
    dispatch_rs1_ready = r1r;
    dispatch_rs1_v     = r1v;
    dispatch_rs1_tag   = r1t;
    dispatch_rs2_ready = r2r;
    dispatch_rs2_v     = r2v;
    dispatch_rs2_tag   = r2t;
    if (push) begin
      e.r1 = e1; e.r2 = e2; e.pc = p; e.imm = p ^ 32'h0000_1234; e.ins = ins; e.tag = t;
      sb.push_back(e);
    end
    step();
    dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TW-1:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    step();
    cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
    dispatch_instr = '0; dispatch_pc = '0; dispatch_imm = '0; dispatch_tag = '0;
    dispatch_rs1_ready = 1'b0; dispatch_rs1_v = '0; dispatch_rs1_tag = '0;
    dispatch_rs2_ready = 1'b0; dispatch_rs2_v = '0; dispatch_rs2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    step(); step();
    rst = 1'b0;

    chk("rst_issue", 32'(comp_issue), 32'd0);
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_rs1", rs1_v, 32'd0);
    chk("rst_rs2", rs2_v, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_tag", 32'(branch_tag), 32'd0);

    // BEQ, both ready: strobe exactly one cycle after capture
    disp(I_BEQ, 32'h100, 2'd2, 1'b1, 32'd5, 2'd0, 1'b1, 32'd5, 2'd0, 1'b1, 32'd5, 32'd5);
    chk("beq_e0", 32'(comp_issue), 32'd0);
    step(); chk("beq_e1", 32'(comp_issue), 32'd1);
    step(); chk("beq_e2", 32'(comp_issue), 32'd0);

    // BNE waiting on tag 3, woken by CDB
    disp(I_BNE, 32'h104, 2'd0, 1'b0, 32'd0, 2'd3, 1'b1, 32'd7, 2'd1, 1'b1, 32'h10, 32'd7);
    chk("bne_wait", 32'(comp_issue), 32'd0);
    cdb(2'd3, 32'h10);
    chk("bne_wake_edge", 32'(comp_issue), 32'd0);
    step(); chk("bne_issue", 32'(comp_issue), 32'd1);
    step(); chk("bne_after", 32'(comp_issue), 32'd0);

    // JAL forced ready, then JALR needing only rs1
    disp(I_JAL, 32'h108, 2'd1, 1'b0, 32'hAA, 2'd3, 1'b0, 32'hBB, 2'd3, 1'b1, 32'hAA, 32'hBB);
    chk("jal_e0", 32'(comp_issue), 32'd0);
    disp(I_JALR, 32'h10C, 2'd2, 1'b1, 32'h100, 2'd0, 1'b0, 32'hCC, 2'd3, 1'b1, 32'h100, 32'hCC);
    chk("jal_issue", 32'(comp_issue), 32'd1);
    step(); chk("jalr_issue", 32'(comp_issue), 32'd1);
    step(); chk("jalr_after", 32'(comp_issue), 32'd0);

    // Non-ready head blocks a ready younger entry
    disp(I_BEQ, 32'h110, 2'd0, 1'b0, 32'd0, 2'd1, 1'b1, 32'd9, 2'd0, 1'b1, 32'h55, 32'd9);
    disp(I_BNE, 32'h114, 2'd2, 1'b1, 32'd3, 2'd0, 1'b1, 32'd4, 2'd0, 1'b1, 32'd3, 32'd4);
    chk("order_blk0", 32'(comp_issue), 32'd0);
    step(); chk("order_blk1", 32'(comp_issue), 32'd0);
    step(); chk("order_blk2", 32'(comp_issue), 32'd0);
    cdb(2'd1, 32'h55);
    chk("order_wake", 32'(comp_issue), 32'd0);
    step(); chk("order_head", 32'(comp_issue), 32'd1);
    step(); chk("order_young", 32'(comp_issue), 32'd1);
    step(); chk("order_idle", 32'(comp_issue), 32'd0);

    // Dispatch-cycle CDB bypass
    cdb_valid = 1'b1; cdb_tag = 2'd2; cdb_data = 32'h77;
    disp(I_BEQ, 32'h118, 2'd3, 1'b0, 32'd0, 2'd2, 1'b1, 32'd1, 2'd0, 1'b1, 32'h77, 32'd1);
    cdb_valid = 1'b0;
    chk("byp_e0", 32'(comp_issue), 32'd0);
    step(); chk("byp_issue", 32'(comp_issue), 32'd1);
    step(); chk("byp_after", 32'(comp_issue), 32'd0);

    // Fill, blocked 5th dispatch, no refill in the freeing cycle, drain
    disp(I_BEQ, 32'h200, 2'd0, 1'b0, 32'd0, 2'd3, 1'b1, 32'd1, 2'd0, 1'b1, 32'h33, 32'd1);
    disp(I_BEQ, 32'h204, 2'd1, 1'b1, 32'd2, 2'd0, 1'b1, 32'd2, 2'd0, 1'b1, 32'd2, 32'd2);
    disp(I_BEQ, 32'h208, 2'd2, 1'b1, 32'd3, 2'd0, 1'b1, 32'd3, 2'd0, 1'b1, 32'd3, 32'd3);
    chk("fill3_full", 32'(rs_full), 32'd0);
    disp(I_BEQ, 32'h20C, 2'd3, 1'b1, 32'd4, 2'd0, 1'b1, 32'd4, 2'd0, 1'b1, 32'd4, 32'd4);
    chk("fill4_full", 32'(rs_full), 32'd1);
    disp(I_BNE, 32'h2F0, 2'd1, 1'b1, 32'hDEAD, 2'd0, 1'b1, 32'hBEEF, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("fifth_full", 32'(rs_full), 32'd1);
    chk("fifth_noiss", 32'(comp_issue), 32'd0);
    cdb(2'd3, 32'h33);
    chk("full_wake", 32'(comp_issue), 32'd0);
    disp(I_BNE, 32'h2F4, 2'd2, 1'b1, 32'hDEAD, 2'd0, 1'b1, 32'hBEEF, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("drain1", 32'(comp_issue), 32'd1);
    chk("drain1_full", 32'(rs_full), 32'd0);
    step(); chk("drain2", 32'(comp_issue), 32'd1);
    step(); chk("drain3", 32'(comp_issue), 32'd1);
    step(); chk("drain4", 32'(comp_issue), 32'd1);
    step(); chk("drain_idle", 32'(comp_issue), 32'd0);
    chk("drain_full", 32'(rs_full), 32'd0);

    // Refill of four after wrap
    disp(I_BNE, 32'h300, 2'd0, 1'b0, 32'd0, 2'd1, 1'b1, 32'd5, 2'd0, 1'b1, 32'h11, 32'd5);
    disp(I_JAL, 32'h304, 2'd1, 1'b0, 32'd6, 2'd2, 1'b0, 32'd6, 2'd2, 1'b1, 32'd6, 32'd6);
    disp(I_JALR, 32'h308, 2'd2, 1'b1, 32'd7, 2'd0, 1'b0, 32'd7, 2'd1, 1'b1, 32'd7, 32'd7);
    disp(I_BEQ, 32'h30C, 2'd3, 1'b1, 32'd8, 2'd0, 1'b1, 32'd8, 2'd0, 1'b1, 32'd8, 32'd8);
    chk("refill_full", 32'(rs_full), 32'd1);
    cdb(2'd1, 32'h11);
    step(); chk("refill1", 32'(comp_issue), 32'd1);
    step(); chk("refill2", 32'(comp_issue), 32'd1);
    step(); chk("refill3", 32'(comp_issue), 32'd1);
    step(); chk("refill4", 32'(comp_issue), 32'd1);
    step(); chk("refill_idle", 32'(comp_issue), 32'd0);

    // Flush with three entries, a ready head and a same-cycle dispatch
    disp(I_BEQ, 32'h400, 2'd0, 1'b0, 32'd0, 2'd1, 1'b1, 32'd1, 2'd0, 1'b1, 32'h44, 32'd1);
    disp(I_BEQ, 32'h404, 2'd2, 1'b1, 32'd2, 2'd0, 1'b1, 32'd2, 2'd0, 1'b1, 32'd2, 32'd2);
    disp(I_BEQ, 32'h408, 2'd3, 1'b1, 32'd3, 2'd0, 1'b1, 32'd3, 2'd0, 1'b1, 32'd3, 32'd3);
    cdb(2'd1, 32'h44);
    chk("fl_pre", 32'(comp_issue), 32'd0);
    sb.delete();
    flush = 1'b1;
    disp(I_BNE, 32'h4F0, 2'd1, 1'b1, 32'hDEAD, 2'd0, 1'b1, 32'hBEEF, 2'd0, 1'b0, 32'd0, 32'd0);
    flush = 1'b0;
    chk("fl_issue", 32'(comp_issue), 32'd0);
    chk("fl_full", 32'(rs_full), 32'd0);
    step(); chk("fl_idle1", 32'(comp_issue), 32'd0);
    step(); chk("fl_idle2", 32'(comp_issue), 32'd0);

    // Count must restart at zero: full only after four new entries
    disp(I_BEQ, 32'h500, 2'd0, 1'b0, 32'd0, 2'd2, 1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0);
    disp(I_BEQ, 32'h504, 2'd1, 1'b0, 32'd0, 2'd2, 1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0);
    disp(I_BEQ, 32'h508, 2'd2, 1'b0, 32'd0, 2'd2, 1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("pf3_full", 32'(rs_full), 32'd0);
    disp(I_BEQ, 32'h50C, 2'd3, 1'b0, 32'd0, 2'd2, 1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0);
    chk("pf4_full", 32'(rs_full), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pf_flush_full", 32'(rs_full), 32'd0);

    disp(I_JAL, 32'h600, 2'd1, 1'b0, 32'h61, 2'd0, 1'b0, 32'h62, 2'd0, 1'b1, 32'h61, 32'h62);
    step(); chk("post_issue", 32'(comp_issue), 32'd1);
    step(); chk("post_idle", 32'(comp_issue), 32'd0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_rs.md
# branch_rs

In-order reservation station for control-flow instructions (JAL, JALR, conditional branches) in the out-of-order core. It sits between dispatch and the branch comparator: it buffers branch µops and snoops the CDB until their source operands are available. It then issues the oldest branch, one per cycle, on the comparator's issue interface (`rs1_v`/`rs2_v`/`pc`/`imm`/`instr`/`branch_tag`/`comp_issue`). Issue is strictly in program order among branches, so that misprediction recovery sees branches resolve oldest-first.

## Interface
- `ROB_DEPTH`, 4: ROB entries. `TW = $clog2(ROB_DEPTH)` is the tag width.
- `RS_DEPTH`, 4: station entries; power of two, ≥2.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: mispredict/exception squash; clears all entries.
- `dispatch_valid` in 1: new branch µop offered.
- `dispatch_instr` in 32: raw instruction word.
- `dispatch_pc` in 32: instruction PC.
- `dispatch_imm` in 32: sign-extended immediate.
- `dispatch_tag` in TW: ROB tag of the branch.
- `dispatch_rs1_ready` in 1: rs1 value valid at dispatch.
- `dispatch_rs1_v` in 32: rs1 value.
- `dispatch_rs1_tag` in TW: ROB tag producing rs1.
- `dispatch_rs2_ready` in 1: rs2 value valid at dispatch.
- `dispatch_rs2_v` in 32: rs2 value.
- `dispatch_rs2_tag` in TW: ROB tag producing rs2.
- `rs_full` out 1: station cannot accept a µop this cycle.
- `cdb_valid` in 1: CDB broadcast valid.
- `cdb_tag` in TW: broadcast ROB tag.
- `cdb_data` in 32: broadcast value.
- `rs1_v` out 32: issued rs1 operand.
- `rs2_v` out 32: issued rs2 operand.
- `pc` out 32: issued PC.
- `imm` out 32: issued immediate.
- `instr` out 32: issued instruction word.
- `branch_tag` out TW: issued ROB tag.
- `comp_issue` out 1: issue strobe to comparator.

## Operation
- Storage is a circular queue of RS_DEPTH entries: head pointer, tail pointer, and a count of width `$clog2(RS_DEPTH)+1`.
- Each entry holds instr, pc, imm, tag, and for each of rs1 and rs2 a ready bit, a 32-bit value and a producer tag.
- `rs_full = (count == RS_DEPTH)`. It is combinational from count.
- Dispatch: when `dispatch_valid && !rs_full`, write the µop at tail and increment tail (wraps modulo RS_DEPTH).
  - Operand ready-forcing by opcode `instr[6:0]`, using the rv32im_types constants:
    - `op_b_jal`: rs1 and rs2 are forced ready.
    - `op_b_jalr`: rs2 is forced ready.
    - `op_b_br`: both operands taken as dispatched.
  - Dispatch bypass: if a CDB broadcast is valid the same cycle and `cdb_tag` matches a not-ready source tag, that source is stored ready with `cdb_data`.
- Wakeup: every occupied, not-ready source whose tag equals `cdb_tag` while `cdb_valid` captures `cdb_data` and sets its ready bit at the clock edge.
- Issue: if count≠0 and the head entry has both ready bits set (registered state only, not same-cycle CDB), then at the edge:
  - load the output registers from the head entry;
  - drive `comp_issue`=1 for the following cycle;
  - increment head and free the entry.
  - Otherwise `comp_issue`=0 the next cycle; the output data registers hold their last value.
- Younger entries never issue past a non-ready head.
- The comparator is single-cycle and never stalls; there is no back-pressure on issue.
- Count update: +1 on dispatch only, −1 on issue only, unchanged when both or neither happen.

## Timing
- Reset (`rst`=1 at an edge): head=tail=count=0; all ready bits 0; `comp_issue`=0; `rs1_v`, `rs2_v`, `pc`, `imm`, `instr`, `branch_tag` all 0; `rs_full`=0.
- Flush: identical to reset for queue state and `comp_issue`. Output data registers may hold stale values.
  - Flush has priority over dispatch, wakeup and issue in the same cycle.
  - A dispatch presented in the flush cycle is dropped.
  - Reset or flush mid-operation discards everything without partial issue.
- Latency: µop dispatched with ready operands at edge E0 → issued at E1, with `comp_issue` high in cycle E1–E2.
  - Operand woken by CDB at edge Ew → issue at Ew+1 at the earliest.
- Full: dispatch is blocked while `rs_full`, even if issue frees a slot that cycle. No same-cycle refill when full.
- Empty: count=0 → no issue. A µop arriving that cycle issues no earlier than the next edge.
- Pointer wrap: tail and head wrap RS_DEPTH-1 → 0 seamlessly.
- `comp_issue` is never high for two consecutive cycles for the same entry.

## Test plan
- Reset, then dispatch BEQ tag=2, rs1=5, rs2=5, both ready → `comp_issue`=1 exactly one cycle after capture, with `rs1_v`=5, `rs2_v`=5, `branch_tag`=2, then 0.
- Dispatch BNE with rs1 waiting on tag 3; next cycle CDB tag=3, data=0x10 → issue the following cycle with `rs1_v`=0x10.
- Dispatch JAL with both ready bits 0 → forced ready, issues after 1 cycle. JALR with only rs1 ready → issues without waiting on rs2.
- Head waits on tag 1 while entry 2 is ready → no issue until CDB tag=1. Then head and entry 2 issue on consecutive cycles, in order.
- Dispatch 4 µops (RS_DEPTH=4) → `rs_full`=1 and a 5th dispatch is ignored. Drain all → count=0 and pointers wrapped to 0. A refill of 4 works.
- `flush` asserted with 3 entries, a ready head and a dispatch in the same cycle → `comp_issue`=0 next cycle, count=0, `rs_full`=0, dropped dispatch never issues.
